fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit handshake bundle: redirect input, instruction bus request/response
// and the instruction-queue head toward decode.
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic [31:0] out_instr;
    logic        out_exc_adel;

    modport master (
        input  redirect_valid, redirect_pc, ireq_ready, iresp_valid, iresp_data, out_ready,
        output ireq_valid, ireq_addr, out_valid, out_pc, out_pcplus4, out_instr, out_exc_adel
    );

    modport slave (
        output redirect_valid, redirect_pc, ireq_ready, iresp_valid, iresp_data, out_ready,
        input  ireq_valid, ireq_addr, out_valid, out_pc, out_pcplus4, out_instr, out_exc_adel
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding bus master feeding a small FIFO of
// {pc, instr, adel} entries toward decode, with redirect and misaligned-PC handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int unsigned PW = (QDEPTH > 2) ? 2 : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } entry_t;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   ireq_addr_q, ireq_addr_d;
    logic          ireq_valid_q, ireq_valid_d;
    logic          drop_q, drop_d;
    logic          halt_q, halt_d;
    entry_t        mem_q [QDEPTH];
    entry_t        mem_d [QDEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          head_valid;
    logic          room;
    logic          push;
    logic          pop;
    entry_t        push_entry;
    entry_t        head;

    assign head_valid = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    // The outstanding transaction reserves a slot so its response can always be queued.
    assign room       = (count_q + CW'(state_q != IDLE)) < CW'(QDEPTH);
    assign pop        = head_valid && bus.out_ready;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        ireq_addr_d  = ireq_addr_q;
        ireq_valid_d = ireq_valid_q;
        drop_d       = drop_q;
        halt_d       = halt_q;
        push         = 1'b0;
        push_entry   = '0;

        unique case (state_q)
            IDLE: begin
                if (!bus.redirect_valid && !halt_q && room) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (fetch_pc_q[1:0] == 2'b00) begin
                        state_d      = REQ;
                        ireq_valid_d = 1'b1;
                        ireq_addr_d  = fetch_pc_q;
                    end else begin
                        push       = 1'b1;
                        push_entry = '{pc: fetch_pc_q, instr: 32'd0, adel: 1'b1};
                        halt_d     = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    drop_d = 1'b1;
                end
                if (bus.ireq_ready) begin
                    state_d      = WAIT;
                    ireq_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (bus.iresp_valid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !bus.redirect_valid) begin
                        push       = 1'b1;
                        push_entry = '{pc: ireq_addr_q, instr: bus.iresp_data, adel: 1'b0};
                    end
                end else if (bus.redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            halt_d     = 1'b0;
        end
    end

    // Redirect flushes the queue outright; push/pop only matter when no redirect.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            ireq_addr_q  <= '0;
            ireq_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            halt_q       <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            ireq_addr_q  <= ireq_addr_d;
            ireq_valid_q <= ireq_valid_d;
            drop_q       <= drop_d;
            halt_q       <= halt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

    assign bus.ireq_valid   = ireq_valid_q;
    assign bus.ireq_addr    = ireq_addr_q;
    assign bus.out_valid    = head_valid;
    assign bus.out_pc       = head_valid ? head.pc : '0;
    assign bus.out_pcplus4  = head_valid ? (head.pc + 32'd4) : '0;
    assign bus.out_instr    = head_valid ? head.instr : '0;
    assign bus.out_exc_adel = head_valid && head.adel;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a bus responder model predicts queued entries
// and request addresses; per-scenario tasks add targeted checks.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    exp_t        exp_out[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr;
    logic [31:0] req_addr;
    logic [31:0] last_req_addr;
    logic [31:0] pend_addr;
    bit          req_open, pend, stale, stray;
    int          pend_cnt, resp_lat, stall_cnt, req_count, pop_count;

    function automatic logic [31:0] resp_word(input logic [31:0] a);
        return (a == RESET_PC) ? 32'h2402_0001 : (a ^ 32'h1357_9BDF);
    endfunction

    // Commit what the next posedge will do, advance one cycle, then model the bus.
    task automatic tick();
        exp_t        e;
        logic [31:0] pc4;
        if (reset) begin
            exp_out.delete();
            exp_addr = RESET_PC;
            req_open = 0;
            pend     = 0;
            stale    = 0;
        end else begin
            if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
                checks++;
                if (exp_out.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got pc=%h instr=%h adel=%b, required no entry",
                             bus.out_pc, bus.out_instr, bus.out_exc_adel);
                end else begin
                    e   = exp_out.pop_front();
                    pc4 = e.pc + 32'd4;
                    pop_count++;
                    if ({bus.out_pc, bus.out_pcplus4, bus.out_instr, bus.out_exc_adel} !==
                        {e.pc, pc4, e.instr, e.adel}) begin
                        errors++;
                        $display("FAIL output_entry got pc=%h pc4=%h instr=%h adel=%b required pc=%h pc4=%h instr=%h adel=%b",
                                 bus.out_pc, bus.out_pcplus4, bus.out_instr, bus.out_exc_adel,
                                 e.pc, pc4, e.instr, e.adel);
                    end
                end
            end
            if (bus.iresp_valid && pend) begin
                if (!stale && !bus.redirect_valid) begin
                    e = '{pc: pend_addr, instr: resp_word(pend_addr), adel: 1'b0};
                    exp_out.push_back(e);
                end
                pend  = 0;
                stale = 0;
            end
            if (bus.ireq_valid && bus.ireq_ready) begin
                pend      = 1;
                pend_addr = bus.ireq_addr;
                pend_cnt  = resp_lat - 1;
                req_open  = 0;
            end
            if (bus.redirect_valid) begin
                exp_out.delete();
                exp_addr = bus.redirect_pc;
                if (bus.ireq_valid || pend) stale = 1;
            end
        end

        @(posedge clk);
        @(negedge clk);

        bus.iresp_valid = 1'b0;
        bus.iresp_data  = '0;
        bus.ireq_ready  = 1'b0;
        if (!reset) begin
            if (pend) begin
                if (pend_cnt <= 0) begin
                    bus.iresp_valid = 1'b1;
                    bus.iresp_data  = resp_word(pend_addr);
                end else begin
                    pend_cnt--;
                end
            end else if (stray) begin
                bus.iresp_valid = 1'b1;
                bus.iresp_data  = 32'hDEAD_BEEF;
                stray = 0;
            end
            if (bus.ireq_valid && !req_open) begin
                req_open      = 1;
                req_addr      = bus.ireq_addr;
                last_req_addr = bus.ireq_addr;
                req_count++;
                checks++;
                if (bus.ireq_addr !== exp_addr || exp_addr[1:0] != 2'b00) begin
                    errors++;
                    $display("FAIL req_addr got %h required %h (aligned)", bus.ireq_addr, exp_addr);
                end
                exp_addr = exp_addr + 32'd4;
            end else if (req_open) begin
                checks++;
                if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== req_addr) begin
                    errors++;
                    $display("FAIL req_hold got valid=%b addr=%h required valid=1 addr=%h",
                             bus.ireq_valid, bus.ireq_addr, req_addr);
                end
            end
            if (bus.ireq_valid && !pend) begin
                if (stall_cnt > 0) stall_cnt--;
                else bus.ireq_ready = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        stall_cnt = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        resp_lat = 4;
        bus.out_ready = 1'b1;
        do_reset();
        checks++;
        if ({bus.ireq_valid, bus.out_valid, bus.out_pc, bus.out_pcplus4, bus.out_instr, bus.out_exc_adel} !== '0) begin
            errors++;
            $display("FAIL reset_state got ireq_valid=%b out_valid=%b pc=%h pc4=%h instr=%h adel=%b required all 0",
                     bus.ireq_valid, bus.out_valid, bus.out_pc, bus.out_pcplus4, bus.out_instr, bus.out_exc_adel);
        end
        tick();
        checks++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req got valid=%b addr=%h required 1 %h", bus.ireq_valid, bus.ireq_addr, RESET_PC);
        end
        for (int i = 0; i < 10 && !pend; i++) tick();
        checks++;
        if (!pend) begin
            errors++;
            $display("FAIL accept_timeout got no acceptance required acceptance within 10 cycles");
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== RESET_PC) begin
            errors++;
            $display("FAIL req_after_midreset got valid=%b addr=%h required 1 %h", bus.ireq_valid, bus.ireq_addr, RESET_PC);
        end
    endtask

    task automatic test_first_fetch();
        resp_lat = 1;
        bus.out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.iresp_valid !== 1'b1) begin
            errors++;
            $display("FAIL no_bypass got out_valid=%b iresp_valid=%b required 0 1", bus.out_valid, bus.iresp_valid);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_pcplus4, bus.out_instr} !== {1'b1, RESET_PC, 32'hBFC0_0004, 32'h2402_0001}) begin
            errors++;
            $display("FAIL first_out got v=%b pc=%h pc4=%h instr=%h required 1 bfc00000 bfc00004 24020001",
                     bus.out_valid, bus.out_pc, bus.out_pcplus4, bus.out_instr);
        end
        pop_count = 0;
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (pop_count < 5) begin
            errors++;
            $display("FAIL stream_progress got %0d pops required at least 5", pop_count);
        end
    endtask

    task automatic test_backpressure();
        int          base;
        logic [31:0] held_pc;
        resp_lat = 1;
        bus.out_ready = 1'b0;
        do_reset();
        base = req_count;
        for (int i = 0; i < 5; i++) tick();
        held_pc = bus.out_pc;
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (req_count - base != 2 || bus.ireq_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_no_req got reqs=%0d ireq_valid=%b required 2 0", req_count - base, bus.ireq_valid);
        end
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, RESET_PC, 32'h2402_0001} || held_pc !== RESET_PC) begin
            errors++;
            $display("FAIL head_stable got v=%b pc=%h earlier=%h instr=%h required 1 %h", bus.out_valid, bus.out_pc,
                     held_pc, bus.out_instr, RESET_PC);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (req_count - base != 3 || bus.out_pc !== 32'hBFC0_0004) begin
            errors++;
            $display("FAIL refill_after_pop got reqs=%0d head=%h required 3 bfc00004", req_count - base, bus.out_pc);
        end
    endtask

    task automatic test_redirect_wait();
        int base;
        resp_lat = 3;
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10 && !pend; i++) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        base = req_count;
        for (int i = 0; i < 20 && req_count == base; i++) tick();
        checks++;
        if (req_count == base || last_req_addr !== 32'h8000_0100) begin
            errors++;
            $display("FAIL redirect_wait_req got reqs=%0d addr=%h required new req 80000100", req_count - base, last_req_addr);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0100) begin
            errors++;
            $display("FAIL redirect_wait_out got v=%b pc=%h required 1 80000100", bus.out_valid, bus.out_pc);
        end
        tick();
    endtask

    task automatic test_redirect_req();
        resp_lat = 1;
        bus.out_ready = 1'b1;
        do_reset();
        stall_cnt = 3;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0200;
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== RESET_PC) begin
            errors++;
            $display("FAIL redirect_req_hold got v=%b addr=%h required 1 %h", bus.ireq_valid, bus.ireq_addr, RESET_PC);
        end
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0200) begin
            errors++;
            $display("FAIL redirect_req_out got v=%b pc=%h required 1 80000200", bus.out_valid, bus.out_pc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        resp_lat = 2;
        bus.out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 10 && !pend; i++) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_1000;
        tick();
        bus.redirect_pc = 32'h8000_2000;
        tick();
        bus.redirect_pc = 32'h8000_3000;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_3000) begin
            errors++;
            $display("FAIL last_redirect_wins got v=%b pc=%h required 1 80003000", bus.out_valid, bus.out_pc);
        end
        tick();
    endtask

    task automatic test_misaligned();
        exp_t e;
        int   base;
        resp_lat = 1;
        bus.out_ready = 1'b0;
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0102;
        tick();
        bus.redirect_valid = 1'b0;
        e = '{pc: 32'h8000_0102, instr: 32'd0, adel: 1'b1};
        exp_out.push_back(e);
        tick();
        checks++;
        if ({bus.out_valid, bus.out_exc_adel, bus.out_instr, bus.out_pc, bus.out_pcplus4} !==
            {1'b1, 1'b1, 32'd0, 32'h8000_0102, 32'h8000_0106}) begin
            errors++;
            $display("FAIL adel_entry got v=%b adel=%b instr=%h pc=%h pc4=%h required 1 1 0 80000102 80000106",
                     bus.out_valid, bus.out_exc_adel, bus.out_instr, bus.out_pc, bus.out_pcplus4);
        end
        base = req_count;
        stray = 1;
        for (int i = 0; i < 8; i++) tick();
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (req_count != base || bus.out_valid !== 1'b0 || bus.ireq_valid !== 1'b0) begin
            errors++;
            $display("FAIL halted got reqs=%0d out_valid=%b ireq_valid=%b required 0 0 0",
                     req_count - base, bus.out_valid, bus.ireq_valid);
        end
    endtask

    task automatic test_wrap();
        resp_lat = 1;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hFFFF_FFFC || bus.out_pcplus4 !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_out got v=%b pc=%h pc4=%h required 1 fffffffc 00000000",
                     bus.out_valid, bus.out_pc, bus.out_pcplus4);
        end
        for (int i = 0; i < 20 && last_req_addr !== 32'h0; i++) tick();
        checks++;
        if (last_req_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_req got %h required 00000000", last_req_addr);
        end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        resp_lat = 1;
        do_reset();
        pop_count = 0;
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            resp_lat = $urandom_range(1, 3);
            if (!req_open) stall_cnt = $urandom_range(0, 2);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        bus.redirect_valid = 1'b0;
        checks++;
        if (pop_count < 20) begin
            errors++;
            $display("FAIL stream_random_progress got %0d pops required at least 20", pop_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.ireq_ready = 1'b0;
        bus.iresp_valid = 1'b0;
        bus.iresp_data = '0;
        bus.out_ready = 1'b0;
        stray = 0;
        req_count = 0;
        pop_count = 0;
        last_req_addr = '1;
        exp_addr = RESET_PC;
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_req();
        test_back_to_back();
        test_misaligned();
        test_wrap();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
